// File: rtl/i2c_slave_regfile.sv
// I2C target with a small byte-wide register file: write pointer + data, read with auto-increment.
// SCL/SDA are oversampled on the system clock; SDA is driven open-drain through sda_oe.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 4,
  parameter int         PTR_W      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_stb,
  output logic [PTR_W-1:0]      wr_idx,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, ADDR, PTR, WRITE, READ, IGNORE} state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [7:0]                  sh_q, sh_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic                        oe_q, oe_d;
  logic                        ack_q, ack_d;
  logic                        busy_q, busy_d;
  logic                        stb_q, stb_d;
  logic [PTR_W-1:0]            idx_q, idx_d;
  logic [NUM_REGS-1:0][7:0]    regs_q, regs_d;

  logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {scl_i, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {sda_i, sda_s1, sda_s2};
    end
  end

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in  = {sh_q[6:0], sda_s2};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      idx_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
    end
  end

  // cnt counts SCL rises within a byte: 8 = data done, 9 = ACK bit sampled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    idx_d   = idx_q;
    regs_d  = regs_q;
    if (start_c) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WRITE: begin
          if (scl_rise) begin
            if (cnt_q < 4'd8) begin
              sh_d  = byte_in;
              cnt_d = cnt_q + 4'd1;
            end else begin
              cnt_d = 4'd9;
            end
            if (cnt_q == 4'd7) begin
              case (state_q)
                ADDR: begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                    ack_d  = 1'b1;
                    busy_d = 1'b1;
                  end else begin
                    state_d = IGNORE;
                  end
                end
                PTR: begin
                  ptr_d = byte_in[PTR_W-1:0];
                  ack_d = 1'b1;
                end
                default: begin
                  regs_d[ptr_q] = byte_in;
                  stb_d         = 1'b1;
                  idx_d         = ptr_q;
                  ptr_d         = ptr_q + 1'b1;
                  ack_d         = 1'b1;
                end
              endcase
            end
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d = ack_q;
            end else if (cnt_q == 4'd9) begin
              oe_d  = 1'b0;
              cnt_d = '0;
              ack_d = 1'b0;
              if (state_q == ADDR) begin
                // R/W bit is still sh_q[0]; a read starts driving bit 7 right away
                if (sh_q[0]) begin
                  state_d = READ;
                  sh_d    = regs_q[ptr_q];
                  oe_d    = ~regs_q[ptr_q][7];
                end else begin
                  state_d = PTR;
                end
              end else begin
                state_d = WRITE;
              end
            end
          end
        end
        READ: begin
          if (scl_rise) begin
            if (cnt_q < 4'd8) begin
              cnt_d = cnt_q + 4'd1;
            end else if (cnt_q == 4'd8) begin
              if (sda_s2) begin
                state_d = IGNORE;
              end else begin
                ptr_d = ptr_q + 1'b1;
                cnt_d = 4'd9;
              end
            end
          end else if (scl_fall) begin
            if (cnt_q == 4'd9) begin
              cnt_d = '0;
              sh_d  = regs_q[ptr_q];
              oe_d  = ~regs_q[ptr_q][7];
            end else if (cnt_q == 4'd8) begin
              oe_d = 1'b0;
            end else if (cnt_q != 4'd0) begin
              sh_d = {sh_q[6:0], 1'b0};
              oe_d = ~sh_q[6];
            end
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  assign sda_oe = oe_q;
  assign regs_o = regs_q;
  assign wr_stb = stb_q;
  assign wr_idx = idx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, register model and write-event scoreboard.
module tb_i2c_slave_regfile;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [31:0] regs_o;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [3:0][7:0] mdl;
  logic [9:0]      exp_q[$];
  logic [7:0]      rd_q[$];
  logic [1:0]      obs_idx[64];
  logic [7:0]      obs_dat[64];
  int              obs_n = 0;
  int              rd_ptr = 0;
  int              oe_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(4), .PTR_W(2)) dut (
    .clock  (clock),
    .reset  (reset),
    .scl_i  (scl_m),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .regs_o (regs_o),
    .wr_stb (wr_stb),
    .wr_idx (wr_idx),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_stb && obs_n < 64) begin
      obs_idx[obs_n] <= wr_idx;
      obs_dat[obs_n] <= regs_o[int'(wr_idx)*8 +: 8];
      obs_n          <= obs_n + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic q();
    repeat (8) @(negedge clock);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; q();
    scl_m = 1'b1; q(); q();
    scl_m = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    b = sda_line; q();
    scl_m = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    mdl = '0;
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    tests++; if (regs_o !== 32'h0) begin fails++; $display("FAIL reset_regs got=%h exp=0", regs_o); end
    tests++; if (wr_stb !== 1'b0) begin fails++; $display("FAIL reset_wr_stb got=%b exp=0", wr_stb); end
    tests++; if (wr_idx !== 2'd0) begin fails++; $display("FAIL reset_wr_idx got=%0d exp=0", wr_idx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write();
    logic a;
    logic [9:0] e;
    bus_start();
    write_byte(8'hA0, a);
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL wr_addr_ack got=%b exp=0", a); end
    write_byte(8'h01, a);
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL wr_ptr_ack got=%b exp=0", a); end
    write_byte(8'hA5, a); exp_q.push_back({2'd1, 8'hA5}); mdl[1] = 8'hA5;
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL wr_data0_ack got=%b exp=0", a); end
    write_byte(8'h3C, a); exp_q.push_back({2'd2, 8'h3C}); mdl[2] = 8'h3C;
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL wr_data1_ack got=%b exp=0", a); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_mid got=%b exp=1", busy); end
    bus_stop(); q();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    tests++; if (regs_o !== mdl) begin fails++; $display("FAIL wr_regs got=%h exp=%h", regs_o, mdl); end
    tests++; if (obs_n - rd_ptr !== exp_q.size()) begin fails++; $display("FAIL wr_stb_count got=%0d exp=%0d", obs_n - rd_ptr, exp_q.size()); end
    while (exp_q.size() > 0 && rd_ptr < obs_n) begin
      e = exp_q.pop_front();
      tests++; if ({obs_idx[rd_ptr], obs_dat[rd_ptr]} !== e) begin fails++; $display("FAIL wr_event got=%h exp=%h", {obs_idx[rd_ptr], obs_dat[rd_ptr]}, e); end
      rd_ptr++;
    end
    exp_q.delete(); rd_ptr = obs_n;
  endtask

  task automatic test_write_wrap();
    logic a;
    logic [9:0] e;
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h03, a);
    write_byte(8'h11, a); exp_q.push_back({2'd3, 8'h11}); mdl[3] = 8'h11;
    write_byte(8'h22, a); exp_q.push_back({2'd0, 8'h22}); mdl[0] = 8'h22;
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL wrap_ack got=%b exp=0", a); end
    bus_stop(); q();
    tests++; if (regs_o !== mdl) begin fails++; $display("FAIL wrap_regs got=%h exp=%h", regs_o, mdl); end
    tests++; if (obs_n - rd_ptr !== exp_q.size()) begin fails++; $display("FAIL wrap_stb_count got=%0d exp=%0d", obs_n - rd_ptr, exp_q.size()); end
    while (exp_q.size() > 0 && rd_ptr < obs_n) begin
      e = exp_q.pop_front();
      tests++; if ({obs_idx[rd_ptr], obs_dat[rd_ptr]} !== e) begin fails++; $display("FAIL wrap_event got=%h exp=%h", {obs_idx[rd_ptr], obs_dat[rd_ptr]}, e); end
      rd_ptr++;
    end
    exp_q.delete(); rd_ptr = obs_n;
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] d, e;
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h02, a);
    bus_rstart();
    write_byte(8'hA1, a);
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL rd_addr_ack got=%b exp=0", a); end
    rd_q.push_back(mdl[2]); rd_q.push_back(mdl[3]); rd_q.push_back(mdl[0]);
    for (int i = 0; i < 3; i++) begin
      read_byte(d);
      write_bit(i == 2);
      e = rd_q.pop_front();
      tests++; if (d !== e) begin fails++; $display("FAIL rd_byte%0d got=%h exp=%h", i, d, e); end
    end
    q();
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rd_release_after_nack got=%b exp=0", sda_oe); end
    bus_stop(); q();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    int oe0, n0;
    oe0 = oe_cnt; n0 = obs_n;
    bus_start();
    write_byte(8'hA2, a);
    tests++; if (a !== 1'b1) begin fails++; $display("FAIL ign_addr_nack got=%b exp=1", a); end
    write_byte(8'hFF, a);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_busy got=%b exp=0", busy); end
    bus_stop(); q();
    tests++; if (oe_cnt !== oe0) begin fails++; $display("FAIL ign_sda_oe_cycles got=%0d exp=%0d", oe_cnt - oe0, 0); end
    tests++; if (regs_o !== mdl) begin fails++; $display("FAIL ign_regs got=%h exp=%h", regs_o, mdl); end
    tests++; if (obs_n !== n0) begin fails++; $display("FAIL ign_wr_stb got=%0d exp=0", obs_n - n0); end
    rd_ptr = obs_n;
  endtask

  task automatic test_partial();
    logic a;
    logic [9:0] e;
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h01, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop(); q();
    tests++; if (regs_o !== mdl) begin fails++; $display("FAIL part_regs got=%h exp=%h", regs_o, mdl); end
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h00, a);
    write_byte(8'h77, a); exp_q.push_back({2'd0, 8'h77}); mdl[0] = 8'h77;
    bus_stop(); q();
    tests++; if (regs_o !== mdl) begin fails++; $display("FAIL part_regs_after got=%h exp=%h", regs_o, mdl); end
    tests++; if (obs_n - rd_ptr !== exp_q.size()) begin fails++; $display("FAIL part_stb_count got=%0d exp=%0d", obs_n - rd_ptr, exp_q.size()); end
    while (exp_q.size() > 0 && rd_ptr < obs_n) begin
      e = exp_q.pop_front();
      tests++; if ({obs_idx[rd_ptr], obs_dat[rd_ptr]} !== e) begin fails++; $display("FAIL part_event got=%h exp=%h", {obs_idx[rd_ptr], obs_dat[rd_ptr]}, e); end
      rd_ptr++;
    end
    exp_q.delete(); rd_ptr = obs_n;
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [9:0] e;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
    tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL rst_mid_ack_driven got=%b exp=1", sda_oe); end
    #2 reset = 1'b1;
    #1;
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_release got=%b exp=0", sda_oe); end
    tests++; if (regs_o !== 32'h0) begin fails++; $display("FAIL rst_mid_regs got=%h exp=0", regs_o); end
    mdl = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    q();
    bus_stop();
    bus_start();
    write_byte(8'hA0, a);
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL rst_mid_next_ack got=%b exp=0", a); end
    write_byte(8'h01, a);
    write_byte(8'h5A, a); exp_q.push_back({2'd1, 8'h5A}); mdl[1] = 8'h5A;
    bus_stop(); q();
    tests++; if (regs_o !== mdl) begin fails++; $display("FAIL rst_mid_regs_after got=%h exp=%h", regs_o, mdl); end
    tests++; if (obs_n - rd_ptr !== exp_q.size()) begin fails++; $display("FAIL rst_mid_stb_count got=%0d exp=%0d", obs_n - rd_ptr, exp_q.size()); end
    while (exp_q.size() > 0 && rd_ptr < obs_n) begin
      e = exp_q.pop_front();
      tests++; if ({obs_idx[rd_ptr], obs_dat[rd_ptr]} !== e) begin fails++; $display("FAIL rst_mid_event got=%h exp=%h", {obs_idx[rd_ptr], obs_dat[rd_ptr]}, e); end
      rd_ptr++;
    end
    exp_q.delete(); rd_ptr = obs_n;
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_wrap();
    test_read();
    test_wrong_addr();
    test_partial();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
